arith_result_accumulator: RTL and testbench
===========================================

// Module: arith_result_accumulator
// PURPOSE
//   Downstream stage of the 3-bit adder/multiplier datapath. Consumes a
//   programmable-length burst of results (4-bit {carry,sum} or 6-bit product),
//   sums them into an accumulator, then presents the total over a valid/ready
//   output handshake. Owns the sequencing that the combinational datapath lacks.
// PARAMETERS
//   ACC_W   8   accumulator / out_acc width (>= 6)
//   CNT_W   4   burst-length width; max burst = 2**CNT_W-1 results
// PORTS
//   clk        in   1      clock, all state on rising edge
//   rst_n      in   1      asynchronous active-low reset
//   start      in   1      begin burst (sampled in IDLE only)
//   len        in   CNT_W  burst length, sampled with start
//   in_valid   in   1      result beat valid
//   in_ready   out  1      stage accepts beat (high only in ACCUM)
//   in_mode    in   1      1 = adder result (in_data[3:0]), 0 = product (in_data[5:0])
//   in_data    in   6      datapath result
//   out_valid  out  1      accumulated total valid (high only in HOLD)
//   out_ready  in   1      consumer takes total
//   out_acc    out  ACC_W  accumulated total
//   out_ovf    out  1      sticky: accumulator exceeded 2**ACC_W-1 this burst
//   busy       out  1      state != IDLE
// BEHAVIOUR
//   Reset: state=IDLE, acc=0, cnt=0, out_ovf=0; in_ready=out_valid=busy=0.
//   Reset mid-burst aborts it; no output produced; ovf cleared.
//   FSM IDLE -> ACCUM -> HOLD -> IDLE.
//   IDLE: start=1 -> acc<=0, ovf<=0, cnt<=len; next = (len==0) ? HOLD : ACCUM.
//   ACCUM: in_ready=1. Beat accepted when in_valid&in_ready:
//     operand = in_mode ? zero-ext(in_data[3:0]) : zero-ext(in_data[5:0]);
//     in_data[5:4] ignored in adder mode. acc <= acc+operand; cnt <= cnt-1.
//     Beat accepted with cnt==1 -> HOLD next cycle.
//     No beat -> hold all state; no timeout.
//   HOLD: out_valid=1; out_acc/out_ovf stable while out_ready=0.
//     out_valid&out_ready -> IDLE next cycle.
//   Latency: out_valid rises the cycle after last accepted beat (len==0:
//     cycle after start). out_acc reads acc register in all states.
//   start outside IDLE ignored (not queued); start in handshake cycle ignored.
//   Overflow: sum computed ACC_W+1 wide; carry-out sets out_ovf (sticky).
// CONFIGURATION
//   ACC_SATURATE_EN defined: on carry-out acc <= all-ones and stays there for
//     rest of burst; out_ovf still set.
//   ACC_SATURATE_EN undefined: acc wraps modulo 2**ACC_W.
// STRUCTURE
//   arith_pkg: state enum {IDLE,ACCUM,HOLD}; MODE_ADD=1'b1, MODE_MUL=1'b0;
//     ADD_RES_W=4, MUL_RES_W=6.
//   Sub-module acc_add_unit: combinational operand select + zero-extend +
//     ACC_W+1 add + (ACC_SATURATE_EN) clamp; returns next acc and carry.
// TESTING
//   1 len=3, MUL beats 49,12,0 -> out_valid cycle after beat 3, out_acc=61, ovf=0.
//   2 len=2, ADD beats in_data=6'b111110, 6'b000011 -> out_acc=17 (14+3).
//   3 len=0 with start -> out_valid next cycle, out_acc=0; out_ready -> IDLE.
//   4 len=6, MUL beats all 49 (294): wrap build out_acc=38, ovf=1;
//     ACC_SATURATE_EN build out_acc=255, ovf=1.
//   5 HOLD, out_ready low 5 cycles, start pulsed -> out_acc stable, in_ready=0,
//     start ignored; IDLE after out_ready.
//   6 rst_n low mid-ACCUM after 2 beats -> IDLE, acc=0, no out_valid;
//     fresh burst len=1 beat 5 -> out_acc=5.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared types and constants for the adder/multiplier result accumulator.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic MODE_ADD  = 1'b1;
    localparam logic MODE_MUL  = 1'b0;
    localparam int   ADD_RES_W = 4;
    localparam int   MUL_RES_W = 6;

endpackage

// File: rtl/acc_add_unit.sv
// Combinational operand select, zero-extend and accumulate step.
// Optional build macro: ACC_SATURATE_EN clamps the accumulator to all-ones
// on carry-out instead of wrapping.
module acc_add_unit
    import arith_pkg::*;
#(
    parameter int ACC_W = 8
) (
    input  logic [ACC_W-1:0] acc,
    input  logic             in_mode,
    input  logic [5:0]       in_data,
    output logic [ACC_W-1:0] acc_next,
    output logic             carry
);

    logic [ACC_W:0] operand;
    logic [ACC_W:0] sum;

    // Adder results are only 4 bits wide; the upper two data bits are dropped.
    always_comb begin
        operand = '0;
        if (in_mode == MODE_ADD) begin
            operand[ADD_RES_W-1:0] = in_data[ADD_RES_W-1:0];
        end else begin
            operand[MUL_RES_W-1:0] = in_data[MUL_RES_W-1:0];
        end
    end

    // One extra bit on the sum exposes the carry-out for overflow tracking.
    always_comb begin
        sum   = {1'b0, acc} + operand;
        carry = sum[ACC_W];
`ifdef ACC_SATURATE_EN
        acc_next = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
        acc_next = sum[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/arith_result_accumulator.sv
// Burst accumulator for adder/multiplier results with valid/ready output.
// Optional build macro: ACC_SATURATE_EN (saturate instead of wrap).
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for start; len sampled with start
//   ACCUM | accepting result beats until cnt beats have been summed
//   HOLD  | total presented on out_valid until out_ready
module arith_result_accumulator
    import arith_pkg::*;
#(
    parameter int ACC_W = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [5:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf,
    output logic             busy
);

    state_t           state;
    state_t           state_nxt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_sum;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic             beat;
    logic             last_beat;
    logic             launch;

    assign launch    = (state == IDLE) && start;
    assign beat      = (state == ACCUM) && in_valid;
    assign last_beat = beat && (cnt == CNT_W'(1));

    acc_add_unit #(
        .ACC_W (ACC_W)
    ) u_add (
        .acc      (acc),
        .in_mode  (in_mode),
        .in_data  (in_data),
        .acc_next (acc_sum),
        .carry    (carry)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; an empty burst goes straight to HOLD.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (len == '0) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (last_beat) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the current state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            HOLD: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    // Accumulator, remaining-beat counter and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (launch) begin
            acc <= '0;
            cnt <= len;
            ovf <= 1'b0;
        end else if (beat) begin
            acc <= acc_sum;
            cnt <= cnt - CNT_W'(1);
            if (carry) begin
                ovf <= 1'b1;
            end
        end
    end

    assign out_acc = acc;
    assign out_ovf = ovf;

endmodule

// File: tb/tb_arith_result_accumulator.sv
// Self-checking bench for arith_result_accumulator: table of bursts plus
// hand sequences for empty burst, output stall and mid-burst reset.
module tb_arith_result_accumulator;

    localparam int ACC_W = 8;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic             in_mode;
    logic [5:0]       in_data;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic             out_ovf;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    arith_result_accumulator #(
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        int         n;
        logic       mode;
        logic [5:0] data [15];
        int         gap_after;
        int         exp_acc;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input int n);
        start = 1'b1;
        len   = CNT_W'(n);
        tick();
        start = 1'b0;
        len   = '0;
    endtask

    task automatic send_beat(input logic mode, input logic [5:0] d);
        in_valid = 1'b1;
        in_mode  = mode;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic take_output(input string name);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, " idle_busy"}, busy, 0);
        check({name, " idle_out_valid"}, out_valid, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        in_mode   = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        for (int v = 0; v < 6; v++) begin
            for (int b = 0; b < 15; b++) vecs[v].data[b] = '0;
            vecs[v].gap_after = -1;
        end
        vecs[0].name = "mul_49_12_0"; vecs[0].n = 3; vecs[0].mode = 1'b0;
        vecs[0].data[0] = 6'd49; vecs[0].data[1] = 6'd12; vecs[0].data[2] = 6'd0;
        vecs[0].gap_after = 0; vecs[0].exp_acc = 61; vecs[0].exp_ovf = 1'b0;

        vecs[1].name = "add_14_3"; vecs[1].n = 2; vecs[1].mode = 1'b1;
        vecs[1].data[0] = 6'b111110; vecs[1].data[1] = 6'b000011;
        vecs[1].exp_acc = 17; vecs[1].exp_ovf = 1'b0;

        vecs[2].name = "mul_49x6_ovf"; vecs[2].n = 6; vecs[2].mode = 1'b0;
        for (int b = 0; b < 6; b++) vecs[2].data[b] = 6'd49;
`ifdef ACC_SATURATE_EN
        vecs[2].exp_acc = 255;
`else
        vecs[2].exp_acc = 38;
`endif
        vecs[2].exp_ovf = 1'b1;

        vecs[3].name = "add_1_after_ovf"; vecs[3].n = 1; vecs[3].mode = 1'b1;
        vecs[3].data[0] = 6'b110001; vecs[3].exp_acc = 1; vecs[3].exp_ovf = 1'b0;

        vecs[4].name = "add_15x15"; vecs[4].n = 15; vecs[4].mode = 1'b1;
        for (int b = 0; b < 15; b++) vecs[4].data[b] = 6'b001111;
        vecs[4].gap_after = 7; vecs[4].exp_acc = 225; vecs[4].exp_ovf = 1'b0;

        vecs[5].name = "mul_63"; vecs[5].n = 1; vecs[5].mode = 1'b0;
        vecs[5].data[0] = 6'd63; vecs[5].exp_acc = 63; vecs[5].exp_ovf = 1'b0;

        repeat (2) tick();
        check("rst busy", busy, 0);
        check("rst in_ready", in_ready, 0);
        check("rst out_valid", out_valid, 0);
        check("rst out_acc", out_acc, 0);
        check("rst out_ovf", out_ovf, 0);
        rst_n = 1'b1;
        tick();

        // Table-driven bursts.
        for (int v = 0; v < 6; v++) begin
            start_burst(vecs[v].n);
            check({vecs[v].name, " busy"}, busy, 1);
            for (int b = 0; b < vecs[v].n; b++) begin
                check({vecs[v].name, " in_ready"}, in_ready, 1);
                check({vecs[v].name, " early_out_valid"}, out_valid, 0);
                send_beat(vecs[v].mode, vecs[v].data[b]);
                if (b == vecs[v].gap_after) begin
                    // No beat offered: everything must hold.
                    tick();
                    tick();
                    check({vecs[v].name, " gap_in_ready"}, in_ready, 1);
                    check({vecs[v].name, " gap_out_valid"}, out_valid, 0);
                end
            end
            check({vecs[v].name, " out_valid"}, out_valid, 1);
            check({vecs[v].name, " in_ready_hold"}, in_ready, 0);
            check({vecs[v].name, " out_acc"}, out_acc, vecs[v].exp_acc);
            check({vecs[v].name, " out_ovf"}, out_ovf, vecs[v].exp_ovf);
            take_output(vecs[v].name);
        end

        // Empty burst: HOLD the cycle after start with a zero total.
        start_burst(0);
        check("len0 out_valid", out_valid, 1);
        check("len0 in_ready", in_ready, 0);
        check("len0 out_acc", out_acc, 0);
        check("len0 out_ovf", out_ovf, 0);
        take_output("len0");

        // Stalled output with start pulses and stray beats during HOLD.
        start_burst(1);
        send_beat(1'b0, 6'd37);
        for (int c = 0; c < 5; c++) begin
            start    = c[0];
            len      = 4'd3;
            in_valid = 1'b1;
            in_data  = 6'd9;
            tick();
            check("stall out_valid", out_valid, 1);
            check("stall in_ready", in_ready, 0);
            check("stall out_acc", out_acc, 37);
        end
        in_valid  = 1'b0;
        start     = 1'b1;
        out_ready = 1'b1;
        tick();
        start     = 1'b0;
        out_ready = 1'b0;
        check("stall release busy", busy, 0);
        tick();
        check("handshake start ignored busy", busy, 0);
        check("handshake start ignored out_acc", out_acc, 37);

        // Reset in the middle of an overflowing burst.
        start_burst(8);
        for (int b = 0; b < 5; b++) send_beat(1'b0, 6'd63);
        check("pre_rst out_ovf", out_ovf, 1);
        check("pre_rst busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst busy", busy, 0);
        check("mid_rst in_ready", in_ready, 0);
        check("mid_rst out_acc", out_acc, 0);
        check("mid_rst out_ovf", out_ovf, 0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("post_rst out_valid", out_valid, 0);
        end
        start_burst(1);
        send_beat(1'b1, 6'd5);
        check("fresh out_valid", out_valid, 1);
        check("fresh out_acc", out_acc, 5);
        check("fresh out_ovf", out_ovf, 0);
        take_output("fresh");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
